// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 16-bit course CPU: accepts one instruction, decodes it,
// steps the operand stage and ALU, then issues one write-back pulse with the ALU result.
module alu_sequencer #(
  parameter int unsigned RF_AW = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [RF_AW-1:0] rf_ra_addr,
  output logic [RF_AW-1:0] rf_rb_addr,
  output logic [7:0]       offset,
  output logic             alu_en,
  output logic             alu_in_sel,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_result,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_addr,
  output logic [15:0]      wb_data,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle, StDecode, StOperand, StExec, StWb, StHalt
  } state_e;

  state_e           r_state, w_state_next;
  logic [15:0]      r_ir;
  logic [RF_AW-1:0] r_ra, r_rb, r_wb_addr;
  logic [7:0]       r_offset;
  logic             r_alu_en, r_sel, r_wb_en, r_illegal;
  logic [3:0]       r_op;
  logic [15:0]      r_wb_data;
  logic [CNT_W-1:0] r_retired;

  logic [4:0] w_opcode;
  logic [3:0] w_op;
  logic       w_is_alu, w_is_imm, w_is_halt, w_is_illegal;

  assign w_opcode = r_ir[15:11];

  always_comb begin
    w_op         = 4'd0;
    w_is_alu     = 1'b0;
    w_is_imm     = 1'b0;
    w_is_halt    = 1'b0;
    w_is_illegal = 1'b0;
    case (w_opcode)
      5'd0:  ;
      5'd1:  w_is_halt = 1'b1;
      5'd2:  begin w_is_alu = 1'b1; w_op = 4'd0; end
      5'd3:  begin w_is_alu = 1'b1; w_op = 4'd1; end
      5'd4:  begin w_is_alu = 1'b1; w_op = 4'd2; end
      5'd5:  begin w_is_alu = 1'b1; w_op = 4'd3; end
      5'd6:  begin w_is_alu = 1'b1; w_op = 4'd4; end
      5'd7:  begin w_is_alu = 1'b1; w_op = 4'd5; end
      5'd8:  begin w_is_alu = 1'b1; w_op = 4'd6; end
      5'd9:  begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_op = 4'd0; end
      5'd10: begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_op = 4'd1; end
      default: w_is_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (instr_valid) w_state_next = StDecode;
      StDecode: begin
        if (w_is_alu)       w_state_next = StOperand;
        else if (w_is_halt) w_state_next = StHalt;
        else                w_state_next = StIdle;
      end
      StOperand: w_state_next = StExec;
      StExec:    w_state_next = StWb;
      StWb:      w_state_next = StIdle;
      StHalt:    w_state_next = StHalt;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    instr_ready = (r_state == StIdle) && !rst;
    busy        = (r_state != StIdle);
    halted      = (r_state == StHalt);
  end

  // Decoded fields are only written in DECODE, so they hold until the next instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_offset  <= '0;
      r_alu_en  <= 1'b0;
      r_sel     <= 1'b0;
      r_op      <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_alu_en <= (r_state == StDecode) && w_is_alu;
      r_wb_en  <= (r_state == StExec);
      if (r_state == StIdle && instr_valid) r_ir <= instr;
      if (r_state == StDecode) begin
        r_op      <= w_op;
        r_sel     <= !w_is_imm;
        r_ra      <= w_is_imm ? RF_AW'(r_ir[10:8]) : RF_AW'(r_ir[7:5]);
        r_rb      <= w_is_imm ? '0 : RF_AW'(r_ir[4:2]);
        r_offset  <= r_ir[7:0];
        r_wb_addr <= RF_AW'(r_ir[10:8]);
        if (w_is_illegal) r_illegal <= 1'b1;
      end
      if (r_state == StExec) begin
        r_wb_data <= alu_result;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign rf_ra_addr = r_ra;
  assign rf_rb_addr = r_rb;
  assign offset     = r_offset;
  assign alu_en     = r_alu_en;
  assign alu_in_sel = r_sel;
  assign alu_op     = r_op;
  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: ALU/immediate flow, back-to-back, NOP/illegal, HALT,
// reset abort and counter wrap (CNT_W = 4).
module tb_alu_sequencer;
  localparam int unsigned RfAw = 3;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic [15:0]     instr = '0;
  logic [15:0]     alu_result = '0;
  logic            instr_ready, alu_en, alu_in_sel, wb_en, busy, halted, illegal;
  logic [RfAw-1:0] rf_ra_addr, rf_rb_addr, wb_addr;
  logic [7:0]      offset;
  logic [3:0]      alu_op;
  logic [15:0]     wb_data;
  logic [CntW-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.RF_AW(RfAw), .CNT_W(CntW)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .offset     (offset),
    .alu_en     (alu_en),
    .alu_in_sel (alu_in_sel),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({rf_ra_addr, rf_rb_addr, offset, alu_en, alu_in_sel, alu_op, wb_en,
                       wb_addr, wb_data, halted, illegal, retired, busy}), 64'd0);
  endtask

  // Issues one ALU instruction from IDLE and checks every stage of its timeline.
  task automatic do_alu(input string tag, input logic [15:0] ins, input logic [15:0] res,
                        input int ra, input int rb, input int sel, input int op, input int off,
                        input int wa, input int ret);
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check_eq({tag, ".dec_alu_en"}, 64'(alu_en), 64'd0);
    check_eq({tag, ".dec_busy"}, 64'(busy), 64'd1);
    tick();
    check_eq({tag, ".alu_en"}, 64'(alu_en), 64'd1);
    check_eq({tag, ".ra"}, 64'(rf_ra_addr), 64'(ra));
    check_eq({tag, ".rb"}, 64'(rf_rb_addr), 64'(rb));
    check_eq({tag, ".sel"}, 64'(alu_in_sel), 64'(sel));
    check_eq({tag, ".op"}, 64'(alu_op), 64'(op));
    check_eq({tag, ".offset"}, 64'(offset), 64'(off));
    alu_result = res;
    tick();
    check_eq({tag, ".exec_en"}, 64'({alu_en, wb_en}), 64'd0);
    tick();
    alu_result = 16'h0;
    check_eq({tag, ".wb_en"}, 64'(wb_en), 64'd1);
    check_eq({tag, ".wb_addr"}, 64'(wb_addr), 64'(wa));
    check_eq({tag, ".wb_data"}, 64'(wb_data), 64'(res));
    check_eq({tag, ".retired"}, 64'(retired), 64'(ret[CntW-1:0]));
    tick();
    check_eq({tag, ".wb_done"}, 64'(wb_en), 64'd0);
    check_eq({tag, ".ready"}, 64'(instr_ready), 64'd1);
  endtask

  task automatic do_nop_like(input string tag, input logic [15:0] ins);
    int seen;
    seen = 0;
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    seen += int'(alu_en) + int'(wb_en);
    check_eq({tag, ".ready_t1"}, 64'(instr_ready), 64'd0);
    tick();
    seen += int'(alu_en) + int'(wb_en);
    check_eq({tag, ".ready_t2"}, 64'(instr_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      seen += int'(alu_en) + int'(wb_en);
    end
    check_eq({tag, ".no_strobes"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int wb_cnt;
    int wb_pos [3];
    int bad;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset.outputs");
    check_eq("reset.ready_in_rst", 64'(instr_ready), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("reset.ready_after", 64'(instr_ready), 64'd1);

    do_alu("add", 16'h1128, 16'h2600, 1, 2, 1, 0, 8'h28, 1, 1);
    do_alu("addi", 16'h4B94, 16'h1234, 3, 0, 0, 0, 8'h94, 3, 2);
    do_alu("xor", 16'h3774, 16'h00FF, 3, 5, 1, 4, 8'h74, 7, 3);

    // Back-to-back: three ADDs with valid held high
    wb_cnt = 0;
    instr = 16'h1128;
    alu_result = 16'h0077;
    instr_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) instr_valid = 1'b0;
      if (wb_en) begin
        if (wb_cnt < 3) wb_pos[wb_cnt] = k;
        wb_cnt++;
      end
    end
    check_eq("b2b.count", 64'(wb_cnt), 64'd3);
    check_eq("b2b.pos0", 64'(wb_pos[0]), 64'd4);
    check_eq("b2b.pos1", 64'(wb_pos[1]), 64'd9);
    check_eq("b2b.pos2", 64'(wb_pos[2]), 64'd14);
    check_eq("b2b.retired", 64'(retired), 64'd6);

    // NOP then illegal
    do_nop_like("nop", 16'h0000);
    check_eq("nop.illegal", 64'(illegal), 64'd0);
    check_eq("nop.retired", 64'(retired), 64'd6);
    do_nop_like("illegal", 16'hF800);
    check_eq("illegal.flag", 64'(illegal), 64'd1);
    do_alu("add_after_ill", 16'h1128, 16'hABCD, 1, 2, 1, 0, 8'h28, 1, 7);
    check_eq("illegal.sticky", 64'(illegal), 64'd1);

    // HALT with valid held
    instr = 16'h0800;
    instr_valid = 1'b1;
    tick();
    check_eq("halt.decode", 64'(halted), 64'd0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (halted !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_eq("halt.held", 64'(bad), 64'd0);
    rst = 1'b1;
    tick();
    check_all_zero("halt.reset");
    instr_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("halt.ready_after", 64'(instr_ready), 64'd1);

    // Reset during EXEC aborts write-back
    instr = 16'h1128;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    alu_result = 16'hBEEF;
    check_eq("abort.in_exec", 64'({busy, rf_ra_addr}), 64'({1'b1, 3'd1}));
    rst = 1'b1;
    tick();
    check_all_zero("abort.outputs");
    rst = 1'b0;
    wb_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (wb_en) wb_cnt++;
    end
    check_eq("abort.no_wb", 64'(wb_cnt), 64'd0);

    // Counter wrap with CNT_W = 4
    for (int i = 1; i <= 16; i++) begin
      do_alu("wrap", 16'h1128, 16'(i), 1, 2, 1, 0, 8'h28, 1, i);
    end
    check_eq("wrap.final", 64'(retired), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
